v_elem_sequencer: RTL
=====================

# v_elem_sequencer

Element-serial controller for the vector register file (32 vregs × 10 elements × 32 bit, one shared element index, synchronous read, write on posedge). Accepts one vector-vector instruction per handshake and walks the element index from 0 to vl-1. For each element it reads vs1/vs2, computes a 32-bit lane result and writes it back to vd. It sits between vector decode and the register file; it owns all register-file address, index and write-enable lines.

## Interface
- NUM_ELEM, 10, elements per vector register (max legal vl)
- XLEN, 32, element width
- VL_W, 4, width of the vl field
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start_valid  in  1  instruction offered
- start_ready  out  1  sequencer can accept (IDLE and not rst)
- op  in  3  0 ADD, 1 SUB (vs1-vs2), 2 AND, 3 OR, 4 XOR, 5 MV (copy vs1), 6–7 reserved
- vd, vs1, vs2  in  5 each  register numbers
- vl  in  VL_W  element count; values >NUM_ELEM clamp to NUM_ELEM
- rf_vd, rf_vs1, rf_vs2  out  5 each  to register file
- rf_ele_index  out  5  element index to register file
- rf_vreg_w  out  1  write enable to register file
- rf_vw_data  out  XLEN  write data
- rf_vs1_data, rf_vs2_data  in  XLEN  registered read data from register file
- busy  out  1  high in READ/WRITE/DONE
- done  out  1  one-cycle completion pulse

## Operation
- op, vd, vs1, vs2 and clamped vl are latched on the accepting edge (start_valid & start_ready). Inputs are ignored otherwise.
- States and transitions:
  - IDLE: on accept, go to READ with idx=0; if the latched vl==0, go to DONE instead.
  - READ: drive ele_index=idx and vreg_w=0. Unconditionally go to WRITE.
  - WRITE: read data is now valid. Drive ele_index=idx, vd and vreg_w=1, with vw_data = ALU result. If idx==vl-1, go to DONE; otherwise go to READ with idx+1.
  - DONE: done=1. Go to IDLE.
- Why the READ/WRITE split: the register file has a single element index shared by read and write, so read and write of different elements cannot overlap. Each element therefore costs 2 cycles.
- ALU: modulo-2^XLEN wraparound; no flags, no saturation.
- Reserved ops (6, 7): the full sequence runs with identical timing, but rf_vreg_w stays 0. done still pulses.
- Register aliasing (vd equal to vs1 and/or vs2) is legal. Element i is read before it is written, and elements are never revisited, so the result is correct.
- rf_vs1/rf_vs2/rf_vd hold the latched values while busy and are 0 in IDLE.
- rf_ele_index never exceeds NUM_ELEM-1.

## Timing
- Reset (rst high at an edge), all outputs registered or decoded from reset state:
  - state IDLE, idx 0
  - rf_vreg_w 0, rf_ele_index 0, rf_vd/rf_vs1/rf_vs2 0, rf_vw_data 0
  - busy 0, done 0
  - start_ready 0 while rst is high, 1 in the first cycle after.
- Reset mid-operation: the next cycle is IDLE with no write issued. Elements already written stay written; there is no rollback and no done pulse.
- Latency, with the accept edge at cycle 0:
  - READ of element i in cycle 2i+1; WRITE of element i in cycle 2i+2, committed at the end of that cycle.
  - done in cycle 2·vl+1 (cycle 1 for vl=0).
  - start_ready returns in cycle 2·vl+2.
- Throughput: one instruction per 2·vl+2 cycles. There is no back-to-back accept during DONE.
- start_valid held high through busy is ignored until IDLE. No buffering.

## Structure
- Shared package v_seq_pkg:
  - op encodings (localparams OP_ADD..OP_MV)
  - state encoding IDLE/READ/WRITE/DONE
  - NUM_ELEM and XLEN defaults, so decode and register file agree.
- Sub-module v_elem_alu: purely combinational (op, a, b → y, wr_en), where wr_en=0 for reserved ops. It instantiates once.
- The sequencer holds the state register, idx counter, latched instruction fields and output decode.

## Test plan
- Reset then idle: rst high 2 cycles → all outputs 0, start_ready 0. After release, start_ready=1 and rf_vreg_w never asserted.
- ADD, vl=3, vd=3, vs1=1 (elements 5,6,7), vs2=2 (elements 10,20,30):
  - v3[0..2]=15,26,37, v3[3..9] unchanged
  - write strobes in cycles 2, 4, 6; done in cycle 7.
- SUB wrap, vl=1: vs1[0]=0, vs2[0]=1 → vd[0]=0xFFFFFFFF. Aliased vd=vs1 gives the same result.
- vl=0 → done in cycle 1, no write. vl=15 → clamped to 10: writes at indices 0..9, done in cycle 21.
- op=7, vl=4 → zero write strobes, done in cycle 9, all registers unchanged.
- rst asserted in cycle 4 of an ADD with vl=5 → elements 0 and 1 written, elements 2..4 untouched, no done pulse, start_ready=1 the next cycle.

Source files
------------

// File: rtl/v_seq_pkg.sv
// Shared constants, op encodings and FSM states for the element-serial vector sequencer.
// Decode, sequencer and register file all size their buses from these values.
package v_seq_pkg;
  localparam int NUM_ELEM = 10;
  localparam int XLEN     = 32;
  localparam int VL_W     = 4;
  localparam int REG_W    = 5;
  localparam int IDX_W    = 5;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MV  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic logic [VL_W-1:0] clamp_vl(input logic [VL_W-1:0] vl);
    return (vl > VL_W'(NUM_ELEM)) ? VL_W'(NUM_ELEM) : vl;
  endfunction
endpackage

// File: rtl/v_elem_sequencer_if.sv
// Instruction handshake plus register-file port of the vector sequencer.
// master = sequencer side, slave = decode/register-file side.
interface v_elem_sequencer_if;
  logic                               start_valid;
  logic                               start_ready;
  logic [2:0]                         op;
  logic [v_seq_pkg::REG_W-1:0]        vd;
  logic [v_seq_pkg::REG_W-1:0]        vs1;
  logic [v_seq_pkg::REG_W-1:0]        vs2;
  logic [v_seq_pkg::VL_W-1:0]         vl;
  logic [v_seq_pkg::REG_W-1:0]        rf_vd;
  logic [v_seq_pkg::REG_W-1:0]        rf_vs1;
  logic [v_seq_pkg::REG_W-1:0]        rf_vs2;
  logic [v_seq_pkg::IDX_W-1:0]        rf_ele_index;
  logic                               rf_vreg_w;
  logic [v_seq_pkg::XLEN-1:0]         rf_vw_data;
  logic [v_seq_pkg::XLEN-1:0]         rf_vs1_data;
  logic [v_seq_pkg::XLEN-1:0]         rf_vs2_data;
  logic                               busy;
  logic                               done;

  modport master (
    input  start_valid, op, vd, vs1, vs2, vl, rf_vs1_data, rf_vs2_data,
    output start_ready, rf_vd, rf_vs1, rf_vs2, rf_ele_index, rf_vreg_w, rf_vw_data, busy, done
  );

  modport slave (
    output start_valid, op, vd, vs1, vs2, vl, rf_vs1_data, rf_vs2_data,
    input  start_ready, rf_vd, rf_vs1, rf_vs2, rf_ele_index, rf_vreg_w, rf_vw_data, busy, done
  );
endinterface

// File: rtl/v_elem_alu.sv
// Combinational lane ALU, wraparound arithmetic, no flags.
// Reserved ops produce zero and deassert wr_en so the sequence runs without writing.
module v_elem_alu
  import v_seq_pkg::*;
(
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y,
  output logic            wr_en
);
  always_comb begin
    y     = '0;
    wr_en = 1'b1;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_MV:   y = a;
      default: wr_en = 1'b0;
    endcase
  end
endmodule

// File: rtl/v_elem_sequencer.sv
// Walks vector elements 0..vl-1 as READ/WRITE pairs (2 cycles/element, done at 2*vl+1 after accept).
// Accepts only in IDLE; start_valid is ignored while busy, nothing is buffered.
module v_elem_sequencer
  import v_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  v_elem_sequencer_if.master sif
);
  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [2:0]         op_q, op_d;
  logic [REG_W-1:0]   vd_q, vd_d, vs1_q, vs1_d, vs2_q, vs2_d;
  logic [VL_W-1:0]    vl_q, vl_d;
  logic [VL_W-1:0]    vl_clamped;
  logic               accept;
  logic               last_elem;
  logic               busy;
  logic               in_write;
  logic [XLEN-1:0]    alu_y;
  logic               alu_wr_en;

  assign vl_clamped = clamp_vl(sif.vl);
  assign accept     = sif.start_valid & sif.start_ready;
  assign last_elem  = (idx_q == (IDX_W'(vl_q) - IDX_W'(1)));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    vd_d    = vd_q;
    vs1_d   = vs1_q;
    vs2_d   = vs2_q;
    vl_d    = vl_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = sif.op;
          vd_d    = sif.vd;
          vs1_d   = sif.vs1;
          vs2_d   = sif.vs2;
          vl_d    = vl_clamped;
          idx_d   = '0;
          state_d = (vl_clamped == '0) ? S_DONE : S_READ;
        end
      end
      S_READ:  state_d = S_WRITE;
      S_WRITE: begin
        if (last_elem) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      op_q    <= '0;
      vd_q    <= '0;
      vs1_q   <= '0;
      vs2_q   <= '0;
      vl_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      vd_q    <= vd_d;
      vs1_q   <= vs1_d;
      vs2_q   <= vs2_d;
      vl_q    <= vl_d;
    end
  end

  v_elem_alu u_alu (
    .op    (op_q),
    .a     (sif.rf_vs1_data),
    .b     (sif.rf_vs2_data),
    .y     (alu_y),
    .wr_en (alu_wr_en)
  );

  // Register numbers are gated so the file sees zeros whenever no instruction is in flight.
  assign busy             = (state_q != S_IDLE);
  assign in_write         = (state_q == S_WRITE);
  assign sif.busy         = busy;
  assign sif.done         = (state_q == S_DONE);
  assign sif.start_ready  = (state_q == S_IDLE) & ~rst;
  assign sif.rf_vd        = busy ? vd_q  : '0;
  assign sif.rf_vs1       = busy ? vs1_q : '0;
  assign sif.rf_vs2       = busy ? vs2_q : '0;
  assign sif.rf_ele_index = idx_q;
  assign sif.rf_vreg_w    = in_write & alu_wr_en;
  assign sif.rf_vw_data   = in_write ? alu_y : '0;
endmodule
